alu_scheduler: RTL and testbench

- Shares the single registered ALU between NUM_REQ requesters, e.g. the main execute path and the branch-compare path.
- Arbitrates round-robin and latches the winner's operation and operands.
- Drives the ALU control and operand inputs, waits out the ALU's one-cycle register latency, and returns the result and zero flag to the winner over a valid/ready response channel.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/alu_scheduler_if.sv | 26 ++
 rtl/alu_scheduler_rr_arbiter.sv | 32 +++
 rtl/alu_scheduler.sv | 120 ++++++++++++
 tb/tb_alu_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, legality check and FSM encoding for the ALU scheduler.
package alu_ctrl_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [OP_W-1:0] OP_AND    = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR     = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD    = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0110;
  localparam logic [OP_W-1:0] OP_ANDALT = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR    = 4'b1100;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } state_t;

  // True for the six codes the ALU implements.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_ANDALT, OP_NOR: is_legal_op = 1'b1;
      default:                                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-facing request/response channel of the ALU scheduler.
interface alu_scheduler_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [PTR_W-1:0]   gnt_idx_c,
  output logic               gnt_any_c
);

  int unsigned j;

  // Scan NUM_REQ slots starting at ptr and take the first requester found.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any_c && req[j]) begin
        gnt_c[j]  = 1'b1;
        gnt_idx_c = PTR_W'(j);
        gnt_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin arbitration.
module alu_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_scheduler_if.slave   bus,
  output logic [OP_W-1:0]  alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;

  logic [NUM_REQ-1:0] gnt_c;
  logic [PTR_W-1:0]   gnt_idx_c;
  logic               gnt_any_c;
  logic [PTR_W-1:0]   nxt_ptr_c;
  logic [OP_W-1:0]    sel_op_c;
  logic [WIDTH-1:0]   sel_a_c;
  logic [WIDTH-1:0]   sel_b_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Route the winner's op and operands using the one-hot grant.
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_c[i]) begin
        sel_op_c = bus.req_op[4*i +: 4];
        sel_a_c  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b_c  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Pointer moves to the slot just after the winner.
  always_comb begin
    nxt_ptr_c = '0;
    if (gnt_idx_c != PTR_W'(NUM_REQ - 1)) nxt_ptr_c = gnt_idx_c + PTR_W'(1);
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      ptr            <= '0;
      owner          <= '0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
      alu_control    <= '0;
      alu_in1        <= '0;
      alu_in2        <= '0;
      busy           <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_any_c) begin
            bus.req_ready <= gnt_c;
            alu_control   <= sel_op_c;
            alu_in1       <= sel_a_c;
            alu_in2       <= sel_b_c;
            bus.rsp_err   <= !is_legal_op(sel_op_c);
            owner         <= gnt_idx_c;
            ptr           <= nxt_ptr_c;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // Illegal codes report a fixed zero result regardless of the ALU.
          if (bus.rsp_err) begin
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b1;
          end else begin
            bus.rsp_result <= alu_result;
            bus.rsp_zero   <= alu_zero;
          end
          bus.rsp_valid <= NUM_REQ'(1) << owner;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready[owner]) begin
            bus.rsp_valid <= '0;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a registered ALU model.
module tb_alu_scheduler;
  import alu_ctrl_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_zero = 1'b1;
  logic             busy;

  int errors = 0;
  int checks = 0;

  alu_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  alu_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .alu_control (alu_control),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (c)
      OP_AND, OP_ANDALT: alu_f = a & b;
      OP_OR:             alu_f = a | b;
      OP_ADD:            alu_f = a + b;
      OP_SUB:            alu_f = a - b;
      OP_NOR:            alu_f = ~(a | b);
      default:           alu_f = '0;
    endcase
  endfunction

  // Registered ALU: samples drive inputs on the rising edge.
  always @(posedge clock) begin
    alu_result <= alu_f(alu_control, alu_in1, alu_in2);
    alu_zero   <= (alu_f(alu_control, alu_in1, alu_in2) == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic v, input logic [3:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[idx]            = v;
    bus.req_op[4*idx +: 4]        = op;
    bus.req_a[WIDTH*idx +: WIDTH] = a;
    bus.req_b[WIDTH*idx +: WIDTH] = b;
  endtask

  // One full transaction from IDLE with the timing checked edge by edge.
  task automatic run_op(input string tag, input int idx, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                        input logic exp_err);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << idx;
    bus.rsp_ready = '0;
    set_req(idx, 1'b1, op, a, b);
    @(negedge clock);
    check({tag, "_accept"}, 64'(bus.req_ready), 64'(oh));
    check({tag, "_alu_ctl"}, 64'(alu_control), 64'(op));
    check({tag, "_alu_in1"}, 64'(alu_in1), 64'(a));
    set_req(idx, 1'b0, op, a, b);
    @(negedge clock);
    check({tag, "_ready_pulse"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_no_early_rsp"}, 64'(bus.rsp_valid), 64'd0);
    @(negedge clock);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
    check({tag, "_result"}, 64'(bus.rsp_result), 64'(exp_res));
    check({tag, "_zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    bus.rsp_ready = oh;
    @(negedge clock);
    check({tag, "_rsp_done"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    bus.rsp_ready = '0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int gcount;
    int last;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    @(negedge clock);

    // Reset values.
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_alu_ctl", 64'(alu_control), 64'd0);
    check("rst_alu_in1", 64'(alu_in1), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("add", 0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op("sub0", 1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    run_op("illegal", 0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
    run_op("nor", 1, OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0, 1'b0);

    // Contention: alternating grants every 4 cycles, starting at 0 after reset.
    pulse_reset();
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, OP_OR, 32'd4, 32'd8);
    bus.rsp_ready = 2'b11;
    gcount = 0;
    last = 0;
    for (int n = 0; n < 40 && gcount < 4; n++) begin
      @(negedge clock);
      if (bus.req_ready != '0) begin
        check($sformatf("rr_grant%0d", gcount), 64'(bus.req_ready),
              64'(NUM_REQ'(1) << (gcount % 2)));
        if (gcount > 0) check($sformatf("rr_spacing%0d", gcount), 64'(n - last), 64'd4);
        last = n;
        gcount++;
      end
    end
    check("rr_grant_count", 64'(gcount), 64'd4);
    set_req(0, 1'b0, OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b0, OP_OR, 32'd4, 32'd8);
    for (int n = 0; n < 10 && busy; n++) @(negedge clock);
    check("rr_drained", 64'(busy), 64'd0);
    check("rr_last_result", 64'(bus.rsp_result), 64'd12);

    // Backpressure on requester 0 with requester 1 pending; rsp_ready[1] ignored.
    bus.rsp_ready = '0;
    set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    @(negedge clock);
    check("bp_accept0", 64'(bus.req_ready), 64'b01);
    set_req(0, 1'b0, OP_ADD, 32'd10, 32'd20);
    set_req(1, 1'b1, OP_SUB, 32'd5, 32'd3);
    bus.rsp_ready = 2'b10;
    @(negedge clock);
    @(negedge clock);
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'b01);
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      check($sformatf("bp_hold_valid%0d", n), 64'(bus.rsp_valid), 64'b01);
      check($sformatf("bp_hold_result%0d", n), 64'(bus.rsp_result), 64'd30);
      check($sformatf("bp_no_accept%0d", n), 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clock);
    check("bp_released", 64'(bus.rsp_valid), 64'd0);
    check("bp_not_in_resp", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    check("bp_accept1", 64'(bus.req_ready), 64'b10);
    set_req(1, 1'b0, OP_SUB, 32'd5, 32'd3);
    bus.rsp_ready = 2'b11;
    @(negedge clock);
    @(negedge clock);
    check("bp_rsp1_valid", 64'(bus.rsp_valid), 64'b10);
    check("bp_rsp1_result", 64'(bus.rsp_result), 64'd2);
    @(negedge clock);
    bus.rsp_ready = '0;

    // Reset during WAIT drops the response.
    set_req(0, 1'b1, OP_ADD, 32'd4, 32'd4);
    @(negedge clock);
    check("mid_accept", 64'(bus.req_ready), 64'b01);
    set_req(0, 1'b0, OP_ADD, 32'd4, 32'd4);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_result", 64'(bus.rsp_result), 64'd0);
    check("mid_rst_zero_err", 64'({bus.rsp_zero, bus.rsp_err}), 64'd0);
    check("mid_rst_alu", 64'({alu_control, alu_in1, alu_in2}), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      check($sformatf("mid_no_rsp%0d", n), 64'(bus.rsp_valid), 64'd0);
    end
    run_op("post_rst_add", 0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
